instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encoder counterpart to the main/ALU decode path. Packs instruction fields (op, funct, rs, rt, rd,
//  shamt, imm, target) into 32-bit MIPS words. Writes them to consecutive instruction-memory addresses
//  through the imem write port. Serves as the program loader for bring-up and self-test before the
//  core leaves reset.
// PARAMETERS
//  OPWIDTH    6   opcode field width
//  FNWIDTH    6   funct field width
//  ADDRWIDTH  6   imem word-address width (64 words)
// PORTS
//  clk       in   1            rising-edge clock
//  reset     in   1            asynchronous, active-high reset
//  start     in   1            begin load session (sampled only in IDLE)
//  base      in   ADDRWIDTH    first word address of session (sampled with start)
//  count     in   ADDRWIDTH+1  words to load (sampled with start)
//  in_valid  in   1            field beat valid
//  in_ready  out  1            encoder accepts a beat this cycle
//  fmt       in   2            00=R, 01=I, 10=J, 11=reserved
//  op        in   OPWIDTH      opcode
//  funct     in   FNWIDTH      funct (R only)
//  rs,rt,rd  in   5 each       register fields
//  shamt     in   5            shift amount (R only)
//  imm       in   16           immediate (I only)
//  target    in   26           jump target (J only)
//  we        out  1            imem write enable
//  wa        out  ADDRWIDTH    imem write address
//  wd        out  32           imem write data
//  busy      out  1            session in progress
//  done      out  1            one-cycle pulse at session end
//  err       out  1            sticky encoding error, cleared by next accepted start
// BEHAVIOUR
//  - Reset (async, active-high): state IDLE; in_ready, we, busy, done, err = 0; wa = 0; wd = 0;
//    address and remaining-count registers = 0. Reset mid-session aborts the session. Words already
//    written stay in imem. No done pulse is issued.
//  - FSM states: IDLE, LOAD, DRAIN.
//    IDLE:  start && count != 0 -> latch base and count, clear err, go to LOAD.
//           start && count == 0 -> clear err, pulse done next cycle, stay in IDLE.
//    LOAD:  in_ready = 1. Each beat (in_valid && in_ready) encodes the word and decrements remaining.
//           Last beat (remaining == 1) -> DRAIN. No beat -> hold (no timeout).
//    DRAIN: in_ready = 0. Last word written this cycle, done = 1. Next state IDLE.
//  - start is ignored in LOAD and DRAIN. busy = (state != IDLE).
//  - Latency: a beat accepted in cycle N gives we = 1 with its wa/wd in cycle N+1. Registered
//    outputs; in_ready does not depend combinationally on in_valid.
//  - Back-to-back beats give one write per cycle. we = 0 in any cycle after a cycle with no accepted
//    beat. wa/wd hold their last value when we = 0.
//  - Address: first write goes to base. Each write increments by 1 modulo 2^ADDRWIDTH (63 -> 0).
//    count > 2^ADDRWIDTH is legal and overwrites earlier words from the same session.
//  - Encoding (wd), fields in MSB-to-LSB order:
//    R: {op, rs, rt, rd, shamt, funct}
//    I: {op, rs, rt, imm}
//    J: {op, target}
//  - Illegal beat: fmt == 11, or fmt == R with op != 0.
//    Writes wd = 32'h0000_0000 (nop) at the normal address. Sets err (sticky).
//    The session continues and the beat counts toward count.
//  - Unused fields for a format are ignored. Encoding is combinational from the beat, registered
//    into wd.
// TESTING
//  1 reset; start, base=0, count=1; beat R, op=0, rs=17, rt=18, rd=16, shamt=0, funct=6'h20
//    -> next cycle we=1, wa=0, wd=32'h0232_8020; done in DRAIN; busy drops next cycle.
//  2 base=62, count=3; beats I addi $8,$0,5 / J op=2, target=26'h000_0010 / R nop
//    -> writes 62:32'h2008_0005, 63:32'h0800_0010, 0:32'h0000_0000; address wraps.
//  3 count=2; in_valid toggled 1,0,0,1 -> exactly 2 writes, we=0 in the gap cycles, addresses
//    consecutive, done after the second write.
//  4 beat fmt=11, then R with op=6'h23 -> both words 0, err=1 and stays 1 after done;
//    next start with count=0 -> err=0 and done pulses.
//  5 assert reset after 2 of 5 beats -> all outputs 0 immediately, state IDLE, no done pulse;
//    start in LOAD/DRAIN ignored (base and count not re-latched).

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I/J instruction fields into 32-bit MIPS words and writes them
// to consecutive imem addresses as a bring-up program loader.
module instr_encoder #(
    parameter int OPWIDTH   = 6,
    parameter int FNWIDTH   = 6,
    parameter int ADDRWIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] base,
    input  logic [ADDRWIDTH:0]   count,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           fmt,
    input  logic [OPWIDTH-1:0]   op,
    input  logic [FNWIDTH-1:0]   funct,
    input  logic [4:0]           rs,
    input  logic [4:0]           rt,
    input  logic [4:0]           rd,
    input  logic [4:0]           shamt,
    input  logic [15:0]          imm,
    input  logic [25:0]          target,
    output logic                 we,
    output logic [ADDRWIDTH-1:0] wa,
    output logic [31:0]          wd,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [ADDRWIDTH:0] ONE = 1;

    logic [1:0]           state;
    logic [ADDRWIDTH-1:0] addr;
    logic [ADDRWIDTH:0]   rem;
    logic                 beat;
    logic                 illegal;
    logic [31:0]          enc;

    assign in_ready = state == LOAD;
    assign busy     = state != IDLE;
    assign beat     = in_valid && in_ready;
    assign illegal  = fmt == 2'b11 || (fmt == 2'b00 && op != '0);

    // Illegal beats still consume a slot but write a nop
    always_comb
        enc = illegal       ? 32'h0000_0000 :
              fmt == 2'b00  ? {op, rs, rt, rd, shamt, funct} :
              fmt == 2'b01  ? {op, rs, rt, imm} :
                              {op, target};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
            we    <= 1'b0;
            wa    <= '0;
            wd    <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            we   <= beat;
            done <= 1'b0;
            if (beat) begin
                wa   <= addr;
                wd   <= enc;
                addr <= addr + 1'b1;
                rem  <= rem - 1'b1;
                if (illegal) err <= 1'b1;
            end
            case (state)
                IDLE:
                    if (start) begin
                        err <= 1'b0;
                        if (count == '0) done <= 1'b1;
                        else begin
                            addr  <= base;
                            rem   <= count;
                            state <= LOAD;
                        end
                    end
                LOAD:
                    if (beat && rem == ONE) begin
                        state <= DRAIN;
                        done  <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed + randomized sessions; a cycle model predicts control outputs
// and queues expected imem writes, which an independent monitor pops and compares.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [5:0]  base;
    logic [6:0]  count;
    logic [1:0]  fmt;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        in_ready, we, busy, done, err;
    logic [5:0]  wa;
    logic [31:0] wd;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t q[$];
    int  total = 0, bad = 0;
    int  mstate, maddr, mrem;
    bit  merr, mon_en;
    bit  nxt_we, nxt_done;
    bit  exp_we, exp_done, exp_busy, exp_err, exp_ready;
    logic [5:0]  last_wa;
    logic [31:0] last_wd;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit ref_illegal(int unsigned f, int unsigned o);
        return f == 3 || (f == 0 && o != 0);
    endfunction

    function automatic logic [31:0] ref_enc(int unsigned f, int unsigned o, int unsigned fn,
                                            int unsigned s, int unsigned t, int unsigned d,
                                            int unsigned sh, int unsigned im, int unsigned tg);
        if (ref_illegal(f, o)) return 32'h0;
        if (f == 0) return o * 67108864 + s * 2097152 + t * 65536 + d * 2048 + sh * 64 + fn;
        if (f == 1) return o * 67108864 + s * 2097152 + t * 65536 + im;
        return o * 67108864 + tg;
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (mon_en && !reset) begin
            check("in_ready", in_ready, exp_ready);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("err", err, exp_err);
            check("we", we, exp_we);
            if (we) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got wa=%0d wd=%h expected no write", wa, wd);
                end else begin
                    w = q.pop_front();
                    check("wa", wa, w.a);
                    check("wd", wd, w.d);
                    last_wa = w.a;
                    last_wd = w.d;
                end
            end else begin
                check("wa_hold", wa, last_wa);
                check("wd_hold", wd, last_wd);
            end
        end
    end

    // Model step: decide from inputs at the negedge, publish expectations after the edge
    task automatic cycle();
        @(negedge clk);
        nxt_we   = 0;
        nxt_done = 0;
        case (mstate)
            0: if (start) begin
                merr = 0;
                if (count == 0) nxt_done = 1;
                else begin
                    maddr  = base;
                    mrem   = count;
                    mstate = 1;
                end
            end
            1: if (in_valid) begin
                nxt_we = 1;
                q.push_back('{6'(maddr), ref_enc(fmt, op, funct, rs, rt, rd, shamt, imm, target)});
                if (ref_illegal(fmt, op)) merr = 1;
                maddr = (maddr + 1) % 64;
                mrem--;
                if (mrem == 0) begin
                    mstate   = 2;
                    nxt_done = 1;
                end
            end
            default: mstate = 0;
        endcase
        @(posedge clk);
        #1;
        exp_we    = nxt_we;
        exp_done  = nxt_done;
        exp_busy  = mstate != 0;
        exp_err   = merr;
        exp_ready = mstate == 1;
    endtask

    task automatic do_reset();
        reset    = 1;
        start    = 0;
        in_valid = 0;
        #1;
        check("rst_we", we, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", in_ready, 0);
        mstate = 0; maddr = 0; mrem = 0; merr = 0;
        q.delete();
        {exp_we, exp_done, exp_busy, exp_err, exp_ready} = '0;
        last_wa = '0;
        last_wd = '0;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic go(input logic [5:0] b, input logic [6:0] c);
        start = 1;
        base  = b;
        count = c;
        cycle();
        start = 0;
    endtask

    task automatic beat(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s, t, d, sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        in_valid = 1;
        fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
        cycle();
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) cycle();
    endtask

    task automatic rand_fields();
        fmt    = 2'($urandom_range(0, 3));
        op     = (fmt == 0 && $urandom_range(0, 4) != 0) ? 6'd0 : 6'($urandom);
        funct  = 6'($urandom);
        rs     = 5'($urandom);
        rt     = 5'($urandom);
        rd     = 5'($urandom);
        shamt  = 5'($urandom);
        imm    = 16'($urandom);
        target = 26'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; start = 0; in_valid = 0; base = 0; count = 0;
        fmt = 0; op = 0; funct = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; target = 0;
        mon_en = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1;
        idle(1);
        // add $16,$17,$18 to word 0
        go(0, 1);
        beat(2'b00, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'h0, 26'h0);
        idle(3);
        // wrap 62 -> 63 -> 0
        go(62, 3);
        beat(2'b01, 6'd8, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'h0);
        beat(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        beat(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0);
        idle(2);
        // gaps in in_valid
        go(20, 2);
        beat(2'b01, 6'd9, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'h0);
        idle(2);
        beat(2'b10, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF);
        idle(2);
        // illegal beats set sticky err; zero-count start clears it
        go(5, 2);
        beat(2'b11, 6'd4, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h55);
        beat(2'b00, 6'h23, 5'd1, 5'd2, 5'd3, 5'd4, 6'h20, 16'h0, 26'h0);
        idle(3);
        go(9, 0);
        idle(2);
        // start during LOAD ignored, then reset mid-session
        go(10, 5);
        start = 1; base = 40; count = 3;
        beat(2'b01, 6'd12, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'h0);
        beat(2'b10, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h123);
        start = 0;
        do_reset();
        idle(3);
        for (int s = 0; s < 30; s++) begin
            go(6'($urandom), (s == 5) ? 7'd70 : 7'($urandom_range(0, 9)));
            for (int k = 0; k < 400 && mstate != 0; k++) begin
                rand_fields();
                in_valid = $urandom_range(0, 9) < 7;
                start    = $urandom_range(0, 9) == 0;
                base     = 6'($urandom);
                count    = 7'($urandom_range(1, 9));
                cycle();
            end
            start = 0;
            if (mstate != 0) begin
                total++;
                bad++;
                $display("FAIL session_end: got state %0d expected 0", mstate);
            end
            idle($urandom_range(0, 2));
        end
        idle(2);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
